seg7_to_hex: RTL and testbench

SEG7_TO_HEX -- requirements
Module: seg7_to_hex

---
 rtl/seg7_to_hex.sv | 179 +++++++++++++++++
 tb/tb_seg7_to_hex.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_to_hex.sv
// -----------------------------------------------------------------------------
// seg7_to_hex
//   Debounces a 7-segment display drive (active-low segment lines) and turns
//   each stable pattern into a hex digit.
//
//   A pattern must be seen unchanged at STABLE_CYCLES+1 consecutive rising
//   edges before it is accepted. Each acceptance raises one one-cycle pulse:
//   o_Valid for a legal hex glyph, or o_Error for any other pattern.
//
// Parameters
//   STABLE_CYCLES : 2..255, consecutive cycles a pattern must be held.
//
// Ports
//   i_Clk                     : clock, rising edge
//   i_Rst_L                   : synchronous active-low reset
//   i_Segment_A..i_Segment_G  : segment lines, 0 = lit (A = bit6 .. G = bit0)
//   o_Value[3:0]              : last accepted legal digit
//   o_Valid                   : one-cycle pulse on legal acceptance
//   o_Error                   : one-cycle pulse on illegal acceptance
//   o_Locked                  : high while the accepted pattern is unchanged
//   o_Err_Count[7:0]          : saturating count of o_Error pulses
//                               (present only with SEG7_ERR_COUNT_EN)
//
// Build option
//   SEG7_ERR_COUNT_EN : when defined, adds o_Err_Count and its counter.
// -----------------------------------------------------------------------------
module seg7_to_hex #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Segment_A,
    input  logic       i_Segment_B,
    input  logic       i_Segment_C,
    input  logic       i_Segment_D,
    input  logic       i_Segment_E,
    input  logic       i_Segment_F,
    input  logic       i_Segment_G,
    output logic [3:0] o_Value,
    output logic       o_Valid,
    output logic       o_Error,
`ifdef SEG7_ERR_COUNT_EN
    output logic [7:0] o_Err_Count,
`endif
    output logic       o_Locked
);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_HELD   = 1'b1
    } state_t;

    localparam logic [7:0] ACCEPT_CNT = 8'(STABLE_CYCLES - 1);
    localparam logic [6:0] BLANK      = 7'b111_1111;

    // Returns {legal, digit}; any pattern that is not a hex glyph is illegal.
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'b000_0001: res = {1'b1, 4'h0};
            7'b100_1111: res = {1'b1, 4'h1};
            7'b001_0010: res = {1'b1, 4'h2};
            7'b000_0110: res = {1'b1, 4'h3};
            7'b100_1100: res = {1'b1, 4'h4};
            7'b010_0100: res = {1'b1, 4'h5};
            7'b010_0000: res = {1'b1, 4'h6};
            7'b000_1111: res = {1'b1, 4'h7};
            7'b000_0000: res = {1'b1, 4'h8};
            7'b000_0100: res = {1'b1, 4'h9};
            7'b000_1000: res = {1'b1, 4'hA};
            7'b110_0000: res = {1'b1, 4'hB};
            7'b011_0001: res = {1'b1, 4'hC};
            7'b100_0010: res = {1'b1, 4'hD};
            7'b011_0000: res = {1'b1, 4'hE};
            7'b011_1000: res = {1'b1, 4'hF};
            default:     res = {1'b0, 4'h0};
        endcase
        return res;
    endfunction

    logic [6:0] pattern_s;
    logic [6:0] sample_r;
    logic [7:0] cnt_r;
    logic [7:0] cnt_s;
    state_t     state_r;
    state_t     state_s;
    logic       restart_r;
    logic       changed_s;
    logic       accept_s;
    logic [4:0] decoded_s;

    assign pattern_s = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                        i_Segment_E, i_Segment_F, i_Segment_G};

    // On acceptance the inputs equal S, so decoding S is the accepted glyph.
    assign decoded_s = decode_seg(sample_r);

    // Next-state and counter logic of the settle/held controller.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        // restart_r makes the first edge after reset behave as a change, so a
        // pattern held across reset (even blank, which equals the reset value
        // of S) still needs the full STABLE_CYCLES+1 edges.
        changed_s = restart_r || (pattern_s != sample_r);
        if (changed_s) begin
            state_s = ST_SETTLE;
            cnt_s   = 8'd0;
        end else begin
            case (state_r)
                ST_SETTLE: begin
                    if (cnt_r == ACCEPT_CNT) begin
                        accept_s = 1'b1;
                        state_s  = ST_HELD;
                    end else begin
                        cnt_s = cnt_r + 8'd1;
                    end
                end
                ST_HELD: begin
                    state_s = ST_HELD;
                end
                default: begin
                    state_s = ST_SETTLE;
                    cnt_s   = 8'd0;
                end
            endcase
        end
    end

    // State, sample register and stability counter.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_r   <= ST_SETTLE;
            cnt_r     <= 8'd0;
            sample_r  <= BLANK;
            restart_r <= 1'b1;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            sample_r  <= pattern_s;
            restart_r <= 1'b0;
        end
    end

    // Registered result outputs; pulses last exactly one cycle because
    // accept_s is only raised on the SETTLE -> HELD transition.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            o_Value  <= 4'h0;
            o_Valid  <= 1'b0;
            o_Error  <= 1'b0;
            o_Locked <= 1'b0;
        end else begin
            o_Valid  <= accept_s & decoded_s[4];
            o_Error  <= accept_s & ~decoded_s[4];
            o_Locked <= (state_s == ST_HELD);
            if (accept_s && decoded_s[4]) begin
                o_Value <= decoded_s[3:0];
            end else begin
                o_Value <= o_Value;
            end
        end
    end

`ifdef SEG7_ERR_COUNT_EN
    // Saturating count of illegal acceptances.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            o_Err_Count <= 8'd0;
        end else if (accept_s && !decoded_s[4] && (o_Err_Count != 8'hFF)) begin
            o_Err_Count <= o_Err_Count + 8'd1;
        end else begin
            o_Err_Count <= o_Err_Count;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_to_hex.sv
module tb_seg7_to_hex;

    localparam int SC = 4;

    logic       clk;
    logic       rst_l;
    logic [6:0] seg;
    logic [3:0] value;
    logic       valid;
    logic       error;
    logic       locked;
`ifdef SEG7_ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    seg7_to_hex #(.STABLE_CYCLES(SC)) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_l),
        .i_Segment_A (seg[6]),
        .i_Segment_B (seg[5]),
        .i_Segment_C (seg[4]),
        .i_Segment_D (seg[3]),
        .i_Segment_E (seg[2]),
        .i_Segment_F (seg[1]),
        .i_Segment_G (seg[0]),
        .o_Value     (value),
        .o_Valid     (valid),
        .o_Error     (error),
`ifdef SEG7_ERR_COUNT_EN
        .o_Err_Count (err_count),
`endif
        .o_Locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // glyph table: index = digit
    logic [6:0] glyph [16];
    initial begin
        glyph[0]  = 7'b0000001; glyph[1]  = 7'b1001111; glyph[2]  = 7'b0010010;
        glyph[3]  = 7'b0000110; glyph[4]  = 7'b1001100; glyph[5]  = 7'b0100100;
        glyph[6]  = 7'b0100000; glyph[7]  = 7'b0001111; glyph[8]  = 7'b0000000;
        glyph[9]  = 7'b0000100; glyph[10] = 7'b0001000; glyph[11] = 7'b1100000;
        glyph[12] = 7'b0110001; glyph[13] = 7'b1000010; glyph[14] = 7'b0110000;
        glyph[15] = 7'b0111000;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid_seen = 0;
    int n_error_seen = 0;

    // reference model state
    int         m_run;
    bit         m_first;
    logic [6:0] m_prev;
    logic [3:0] m_value;
    logic       m_valid, m_error, m_locked;
    int         m_errcnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: a pattern is accepted at the (SC+1)-th consecutive edge it is seen.
    task automatic model_edge(input logic [6:0] pat, input logic r);
        int  dig;
        bit  acc;
        if (!r) begin
            m_run = 0; m_first = 1'b1; m_value = 4'h0;
            m_valid = 1'b0; m_error = 1'b0; m_locked = 1'b0; m_errcnt = 0;
        end else begin
            if (m_first || pat != m_prev) m_run = 1;
            else if (m_run < SC + 2) m_run = m_run + 1;
            m_first = 1'b0;
            m_prev  = pat;
            acc = (m_run == SC + 1);
            dig = -1;
            for (int i = 0; i < 16; i++) if (glyph[i] == pat) dig = i;
            m_valid  = acc && (dig >= 0);
            m_error  = acc && (dig < 0);
            if (m_valid) m_value = 4'(dig);
            m_locked = (m_run >= SC + 1);
            if (m_error && m_errcnt < 255) m_errcnt++;
        end
    endtask

    // Drive one cycle, then compare all outputs against the model.
    task automatic cycle(input logic [6:0] pat, input logic r);
        seg   = pat;
        rst_l = r;
        @(posedge clk);
        model_edge(pat, r);
        @(negedge clk);
        if (valid === 1'b1) n_valid_seen++;
        if (error === 1'b1) n_error_seen++;
        check("value",  32'(value),  32'(m_value));
        check("valid",  32'(valid),  32'(m_valid));
        check("error",  32'(error),  32'(m_error));
        check("locked", 32'(locked), 32'(m_locked));
        check("excl",   32'(valid & error), 32'd0);
`ifdef SEG7_ERR_COUNT_EN
        check("errcnt", 32'(err_count), 32'(m_errcnt));
`endif
    endtask

    task automatic hold(input logic [6:0] pat, input int n);
        for (int i = 0; i < n; i++) cycle(pat, 1'b1);
    endtask

    initial begin
        logic [6:0] cur;
        int         len;
        m_first = 1'b1; m_run = 0; m_prev = 7'h7F; m_value = 4'h0;
        m_valid = 1'b0; m_error = 1'b0; m_locked = 1'b0; m_errcnt = 0;
        seg = 7'h7F; rst_l = 1'b0;
        @(negedge clk);

        // reset
        cycle(7'h7F, 1'b0);
        cycle(7'h7F, 1'b0);
        check("rst_value", 32'(value), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);

        // E held: pulse after edge 5
        hold(glyph[14], SC);
        check("e_early_valid", 32'(valid), 32'd0);
        cycle(glyph[14], 1'b1);
        check("e_valid", 32'(valid), 32'd1);
        check("e_value", 32'(value), 32'hE);
        check("e_locked", 32'(locked), 32'd1);

        // 3 for 2 cycles, then 1 held
        n_valid_seen = 0;
        hold(glyph[3], 2);
        hold(glyph[1], 8);
        check("short3_pulses", 32'(n_valid_seen), 32'd1);
        check("short3_value", 32'(value), 32'h1);

        // blank held: one error, value unchanged
        n_error_seen = 0; n_valid_seen = 0;
        hold(7'h7F, 10);
        check("blank_errors", 32'(n_error_seen), 32'd1);
        check("blank_valids", 32'(n_valid_seen), 32'd0);
        check("blank_value", 32'(value), 32'h1);
`ifdef SEG7_ERR_COUNT_EN
        check("blank_errcnt", 32'(err_count), 32'd1);
`endif

        // 8, glitch to 0 for one cycle, back to 8
        n_valid_seen = 0;
        hold(glyph[8], 7);
        hold(glyph[0], 1);
        hold(glyph[8], 7);
        check("glitch_pulses", 32'(n_valid_seen), 32'd2);
        check("glitch_value", 32'(value), 32'h8);

        // reset in the middle of settling 9
        hold(glyph[9], 2);
        cycle(glyph[9], 1'b0);
        check("mid_rst_value", 32'(value), 32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        hold(glyph[9], SC);
        check("post_rst_early", 32'(valid), 32'd0);
        cycle(glyph[9], 1'b1);
        check("post_rst_valid", 32'(valid), 32'd1);
        check("post_rst_value", 32'(value), 32'h9);

        // blank held across reset also needs SC+1 edges after release
        hold(7'h7F, 3);
        cycle(7'h7F, 1'b0);
        hold(7'h7F, SC);
        check("blank_rst_early", 32'(error), 32'd0);
        cycle(7'h7F, 1'b1);
        check("blank_rst_error", 32'(error), 32'd1);

        // randomized patterns and hold lengths
        for (int k = 0; k < 120; k++) begin
            case ($urandom_range(0, 3))
                0:       cur = 7'($urandom);
                default: cur = glyph[$urandom_range(0, 15)];
            endcase
            len = $urandom_range(1, SC + 4);
            if ($urandom_range(0, 40) == 0) cycle(cur, 1'b0);
            hold(cur, len);
        end

`ifdef SEG7_ERR_COUNT_EN
        // saturation of the error counter
        cycle(7'h7F, 1'b0);
        for (int k = 0; k < 150; k++) begin
            hold(7'h7F, SC + 1);
            hold(7'h7E, SC + 1);
        end
        check("errcnt_sat", 32'(err_count), 32'd255);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
